// File: rtl/decode_ctrl_pipe.sv
// RV32/RV64 integer decoder with a one-entry registered control stage.
// Inserts load-use bubbles and counts them in a saturating counter.
module decode_ctrl_pipe #(
    parameter int XLEN    = 32,
    parameter int RV64_EN = 0,
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic               ex_ready_i,
    input  logic               flush_i,
    output logic               ctrl_valid_o,
    output logic               i_en_o,
    output logic               r_en_o,
    output logic               s_en_o,
    output logic               sb_en_o,
    output logic               u_en_o,
    output logic               uj_en_o,
    output logic               rwr_en_o,
    output logic               dwr_en_o,
    output logic               dr_en_o,
    output logic               jalre_o,
    output logic               uje_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic               illegal_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef struct packed {
        logic               valid;
        logic               i_en;
        logic               r_en;
        logic               s_en;
        logic               sb_en;
        logic               u_en;
        logic               uj_en;
        logic               rwr_en;
        logic               dwr_en;
        logic               dr_en;
        logic               jalre;
        logic               uje;
        logic               illegal;
        logic [ALUOP_W-1:0] aluop;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
    } ctrl_t;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_SUB  = 5'd10;
    localparam logic [4:0] OP_BEQ  = 5'd11;
    localparam logic [4:0] OP_BNE  = 5'd12;
    localparam logic [4:0] OP_BLT  = 5'd13;
    localparam logic [4:0] OP_BGE  = 5'd14;
    localparam logic [4:0] OP_BLTU = 5'd15;
    localparam logic [4:0] OP_BGEU = 5'd16;
    localparam logic [4:0] OP_JAL  = 5'd17;

    localparam logic RV64 = (RV64_EN != 0);
    localparam logic X64  = (XLEN == 64);

    // Returns {legal, aluop} for OP / OP-IMM and their W variants.
    function automatic logic [5:0] arith(
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic       imm,
        input logic       w
    );
        logic [6:0] sh;
        logic       f7_ok;
        logic [5:0] res;
        sh    = (imm && !w && X64) ? {f7[6:1], 1'b0} : f7;
        f7_ok = imm || (f7 == 7'h00);
        res   = 6'd0;
        if (!w || f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5) begin
            case (f3)
                3'd0: begin
                    if (f7_ok)
                        res = {1'b1, OP_ADD};
                    else if (f7 == 7'h20)
                        res = {1'b1, OP_SUB};
                end
                3'd1: if (sh == 7'h00) res = {1'b1, OP_SLL};
                3'd2: if (f7_ok) res = {1'b1, OP_SLT};
                3'd3: if (f7_ok) res = {1'b1, OP_SLTU};
                3'd4: if (f7_ok) res = {1'b1, OP_XOR};
                3'd5: begin
                    if (sh == 7'h00)
                        res = {1'b1, OP_SRL};
                    else if (sh == 7'h20)
                        res = {1'b1, OP_SRA};
                end
                3'd6: if (f7_ok) res = {1'b1, OP_OR};
                default: if (f7_ok) res = {1'b1, OP_AND};
            endcase
        end
        return res;
    endfunction

    ctrl_t            ctrl_q, ctrl_d, dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [5:0]       alu;
    logic             legal;
    logic             uses_rs1, uses_rs2, hazard;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.rd    = instr_i[11:7];
        dec.rs1   = instr_i[19:15];
        dec.rs2   = instr_i[24:20];
        alu       = 6'd0;
        legal     = 1'b1;
        case (opc)
            7'h03: begin
                dec.i_en   = 1'b1;
                dec.rwr_en = 1'b1;
                dec.dr_en  = 1'b1;
            end
            7'h13, 7'h1B: begin
                dec.i_en   = 1'b1;
                dec.rwr_en = 1'b1;
                alu   = arith(f3, f7, 1'b1, opc[3]);
                legal = alu[5] && (!opc[3] || RV64);
            end
            7'h33, 7'h3B: begin
                dec.r_en   = 1'b1;
                dec.rwr_en = 1'b1;
                alu   = arith(f3, f7, 1'b0, opc[3]);
                legal = alu[5] && (!opc[3] || RV64);
            end
            7'h23: begin
                dec.s_en   = 1'b1;
                dec.dwr_en = 1'b1;
            end
            7'h63: begin
                dec.sb_en = 1'b1;
                case (f3)
                    3'd0: alu = {1'b1, OP_BEQ};
                    3'd1: alu = {1'b1, OP_BNE};
                    3'd4: alu = {1'b1, OP_BLT};
                    3'd5: alu = {1'b1, OP_BGE};
                    3'd6: alu = {1'b1, OP_BLTU};
                    3'd7: alu = {1'b1, OP_BGEU};
                    default: legal = 1'b0;
                endcase
            end
            7'h67: begin
                dec.i_en   = 1'b1;
                dec.rwr_en = 1'b1;
                dec.jalre  = 1'b1;
            end
            7'h73: dec.i_en = 1'b1;
            7'h17, 7'h37: begin
                dec.u_en   = 1'b1;
                dec.rwr_en = 1'b1;
            end
            7'h6F: begin
                dec.uj_en  = 1'b1;
                dec.rwr_en = 1'b1;
                dec.uje    = 1'b1;
                alu        = {1'b1, OP_JAL};
            end
            default: legal = 1'b0;
        endcase
        dec.aluop = ALUOP_W'(alu[4:0]);
        // Illegal words still advance so execute can raise the trap.
        if (!legal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.rd      = instr_i[11:7];
            dec.rs1     = instr_i[19:15];
            dec.rs2     = instr_i[24:20];
        end
    end

    assign uses_rs1 = dec.r_en | dec.i_en | dec.s_en | dec.sb_en | dec.jalre;
    assign uses_rs2 = dec.r_en | dec.s_en | dec.sb_en;

    assign hazard = ctrl_q.valid && ctrl_q.dr_en && (ctrl_q.rd != 5'd0)
                 && instr_valid_i
                 && ((uses_rs1 && dec.rs1 == ctrl_q.rd)
                  || (uses_rs2 && dec.rs2 == ctrl_q.rd));

    assign instr_ready_o = (!ctrl_q.valid || ex_ready_i) && !hazard && !flush_i;

    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            ctrl_d = '0;
        end else if (ctrl_q.valid && !ex_ready_i) begin
            ctrl_d = ctrl_q;
        end else if (hazard) begin
            ctrl_d = '0;
            if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end else if (instr_valid_i && instr_ready_o) begin
            ctrl_d = dec;
        end else begin
            ctrl_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ctrl_valid_o = ctrl_q.valid;
    assign i_en_o       = ctrl_q.i_en;
    assign r_en_o       = ctrl_q.r_en;
    assign s_en_o       = ctrl_q.s_en;
    assign sb_en_o      = ctrl_q.sb_en;
    assign u_en_o       = ctrl_q.u_en;
    assign uj_en_o      = ctrl_q.uj_en;
    assign rwr_en_o     = ctrl_q.rwr_en;
    assign dwr_en_o     = ctrl_q.dwr_en;
    assign dr_en_o      = ctrl_q.dr_en;
    assign jalre_o      = ctrl_q.jalre;
    assign uje_o        = ctrl_q.uje;
    assign illegal_o    = ctrl_q.illegal;
    assign aluop_o      = ctrl_q.aluop;
    assign rd_o         = ctrl_q.rd;
    assign rs1_o        = ctrl_q.rs1;
    assign rs2_o        = ctrl_q.rs2;
    assign stall_cnt_o  = cnt_q;

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter XLEN, 32, datapath width; legal values 32 or 64.
REQ-002 Parameter RV64_EN, 0, 1 decodes opcodes 0x1B/0x3B; 0 flags them illegal.
REQ-003 Parameter ALUOP_W, 6, aluop_o width; minimum 5.
REQ-004 Parameter CNT_W, 16, stall_cnt_o width.
REQ-005 clk_i  in  1  sole clock; all state rising-edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 instr_i  in  32  instruction word from fetch.
REQ-008 instr_valid_i  in  1  instr_i is valid.
REQ-009 instr_ready_o  out  1  decoder accepts instr_i this cycle.
REQ-010 ex_ready_i  in  1  execute stage consumes the output register this cycle.
REQ-011 flush_i  in  1  discard held and incoming instruction (taken branch/jump).
REQ-012 ctrl_valid_o  out  1  output register holds a valid decoded instruction.
REQ-013 i_en_o, r_en_o, s_en_o, sb_en_o, u_en_o, uj_en_o  out  1 each  instruction-format flags.
REQ-014 rwr_en_o, dwr_en_o, dr_en_o, jalre_o, uje_o  out  1 each  reg write, mem write, mem read, JALR, JAL.
REQ-015 aluop_o  out  ALUOP_W  ALU operation code.
REQ-016 rd_o, rs1_o, rs2_o  out  5 each  register indices (instr bits 11:7, 19:15, 24:20).
REQ-017 illegal_o  out  1  unrecognised or disabled opcode.
REQ-018 stall_cnt_o  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-019 All outputs except instr_ready_o SHALL be registered; decode latency = 1 cycle from acceptance.
REQ-020 Acceptance SHALL occur when instr_valid_i && instr_ready_o.
REQ-021 instr_ready_o SHALL = (!ctrl_valid_o || ex_ready_i) && !hazard && !flush_i.
REQ-022 hazard SHALL = ctrl_valid_o && dr_en_o && rd_o!=0 && instr_valid_i && ((uses_rs1 && rs1==rd_o) || (uses_rs2 && rs2==rd_o)); uses_rs1 = R/I/S/SB/JALR, uses_rs2 = R/S/SB.
REQ-023 On hazard && ex_ready_i the output register SHALL load a bubble (ctrl_valid_o=0, all enables 0) and stall_cnt_o SHALL increment, saturating at all-ones.
REQ-024 When ctrl_valid_o && !ex_ready_i the output register SHALL hold all values unchanged.
REQ-025 Flush_i SHALL clear ctrl_valid_o next cycle and block acceptance that cycle; flush overrides hazard and acceptance; flush with hazard does not increment stall_cnt_o.
REQ-026 When the register is free and no instruction is accepted, ctrl_valid_o SHALL go 0.
REQ-027 Format flags: I=0x03/0x13/0x67/0x73 (+0x1B if RV64_EN), R=0x33 (+0x3B), S=0x23, SB=0x63, U=0x17/0x37, UJ=0x6F.
REQ-028 rwr_en_o SHALL be 1 for R, OP-IMM(W), LOAD, JALR, JAL, LUI, AUIPC; dwr_en_o for STORE; dr_en_o for LOAD; jalre_o for 0x67; uje_o for 0x6F.
REQ-029 aluop codes: ADD=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 SUB=10 BEQ=11 BNE=12 BLT=13 BGE=14 BLTU=15 BGEU=16 JAL=17, all else 0, zero-extended to ALUOP_W.
REQ-030 OP-IMM non-shift ops SHALL ignore funct7; shifts use funct7 (0x00 SLLI/SRLI, 0x20 SRAI; with XLEN=64 funct7[0] ignored).
REQ-031 OP with funct7 not 0x00/0x20 or undefined funct3/funct7 pair, branch funct3 2/3, or any other opcode SHALL set illegal_o=1, all enables 0, aluop_o=0, ctrl_valid_o=1.
REQ-032 Instruction bits [1:0]!=2'b11 SHALL be illegal.

Reset
REQ-033 With rst_i high at a rising edge, all registered outputs and stall_cnt_o SHALL be 0 next cycle; reset overrides flush, hazard and acceptance.
REQ-034 instr_ready_o SHALL be 1 in the first cycle after reset (register empty, no flush).

Verification
REQ-035 0x00500093 accepted, ex_ready_i=1 -> next cycle ctrl_valid_o=1, i_en_o=1, rwr_en_o=1, aluop_o=1, rd_o=1.
REQ-036 0x402081B3 -> r_en_o=1, aluop_o=10, rd_o=3, rs1_o=1, rs2_o=2.
REQ-037 0x0000A103 then 0x002101B3 back-to-back, ex_ready_i=1 -> one bubble cycle, add emitted one cycle later, stall_cnt_o=1.
REQ-038 ex_ready_i=0 for 3 cycles with valid output -> outputs stable, instr_ready_o=0, no input lost.
REQ-039 flush_i pulse while ctrl_valid_o=1 and instr_valid_i=1 -> next cycle ctrl_valid_o=0, instruction not accepted.
REQ-040 RV64_EN=0, 0x0010809B -> illegal_o=1, rwr_en_o=0, ctrl_valid_o=1; RV64_EN=1 -> i_en_o=1, aluop_o=1.
